// File: rtl/bexkat1_regfile.sv
// bexkat1 architectural register file: r0-r14, banked USP/SSP as r15, sticky halt, retired-write counter.
// Optional same-cycle write-to-read bypass is enabled by defining BEXKAT1_REGFILE_BYPASS_EN.
module bexkat1_regfile #(
    parameter int NREGS = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       reg_write_i,
    input  logic [3:0]       reg_write_addr_i,
    input  logic [31:0]      wb_data_i,
    input  logic [31:0]      sp_data_i,
    input  logic [3:0]       bank_i,
    input  logic             halt_i,
    input  logic [3:0]       ra_addr_i,
    input  logic [3:0]       rb_addr_i,
    input  logic             rd_bank_i,
    output logic [31:0]      ra_data_o,
    output logic [31:0]      rb_data_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int NGPR = NREGS - 1;
    localparam logic [3:0] SP_ADDR = 4'd15;

    logic [31:0]      gpr_r [0:NGPR-1];
    logic [31:0]      usp_r;
    logic [31:0]      ssp_r;
    logic             halted_r;
    logic [CNT_W-1:0] retired_r;

    logic             commit_en_s;
    logic             wb_is_sp_s;
    logic             gpr_we_s;
    logic             sp_we_s;
    logic [31:0]      sp_wdata_s;
    logic             sp_sel_sup_s;
    logic             any_commit_s;
    logic             unused_bank_s;

    assign unused_bank_s = ^bank_i[3:1];

    // Decode the write-back command into the physical write strobes for this edge.
    always_comb begin
        commit_en_s  = ~halted_r;
        wb_is_sp_s   = (reg_write_addr_i == SP_ADDR);
        gpr_we_s     = commit_en_s & reg_write_i[0] & ~wb_is_sp_s;
        sp_we_s      = commit_en_s & (reg_write_i[1] | (reg_write_i[0] & wb_is_sp_s));
        sp_sel_sup_s = bank_i[0];
        any_commit_s = commit_en_s & (reg_write_i != 2'b00);
        // A result targeting r15 outranks the implicit SP update in the same cycle.
        if (reg_write_i[0] && wb_is_sp_s) begin
            sp_wdata_s = wb_data_i;
        end else begin
            sp_wdata_s = sp_data_i;
        end
    end

    function automatic logic [31:0] stored_read(input logic [3:0] addr, input logic sup);
        logic [31:0] val;
        if (addr == SP_ADDR) begin
            if (sup) begin
                val = ssp_r;
            end else begin
                val = usp_r;
            end
        end else begin
            val = gpr_r[addr];
        end
        return val;
    endfunction

    function automatic logic [31:0] port_read(input logic [3:0] addr, input logic sup);
        logic [31:0] val;
`ifdef BEXKAT1_REGFILE_BYPASS_EN
        if (gpr_we_s && (addr == reg_write_addr_i)) begin
            val = wb_data_i;
        end else if (sp_we_s && (addr == SP_ADDR) && (sup == sp_sel_sup_s)) begin
            val = sp_wdata_s;
        end else begin
            val = stored_read(addr, sup);
        end
`else
        val = stored_read(addr, sup);
`endif
        return val;
    endfunction

    // Read ports: combinational from address, stored state and (optionally) the committing write.
    always_comb begin
        ra_data_o = port_read(ra_addr_i, rd_bank_i);
        rb_data_o = port_read(rb_addr_i, rd_bank_i);
    end

    // General register storage r0-r14.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NGPR; i++) begin
                gpr_r[i] <= 32'h0;
            end
        end else if (gpr_we_s) begin
            gpr_r[reg_write_addr_i] <= wb_data_i;
        end else begin
            gpr_r[reg_write_addr_i] <= gpr_r[reg_write_addr_i];
        end
    end

    // Banked stack pointers: bank bit0 selects supervisor (SSP) over user (USP).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            usp_r <= 32'h0;
            ssp_r <= 32'h0;
        end else if (sp_we_s) begin
            if (sp_sel_sup_s) begin
                ssp_r <= sp_wdata_s;
            end else begin
                usp_r <= sp_wdata_s;
            end
        end else begin
            usp_r <= usp_r;
            ssp_r <= ssp_r;
        end
    end

    // Sticky halt and retired-write counter; both freeze once halted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_r  <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            if (any_commit_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
            if (commit_en_s && halt_i) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

    assign halted_o  = halted_r;
    assign retired_o = retired_r;

endmodule
